perceptron_trainer: RTL and testbench

- Sequential training engine that owns and writes the weight/bias store read by the combinational perceptron inference units.
- Accepts labelled binary samples and serially computes the weighted sum.
- Applies the perceptron learning rule on a misprediction.
- Exposes a read port so inference units fetch the trained weights and bias.

---
 rtl/perceptron_trainer_pkg.sv | 52 +++++
 rtl/perceptron_trainer_weight_store.sv | 53 +++++
 rtl/perceptron_trainer.sv | 183 ++++++++++++++++++
 tb/tb_perceptron_trainer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_trainer_pkg.sv
// rtl/perceptron_trainer_pkg.sv - shared types, defaults and saturating helpers for the perceptron trainer
//
// Purpose: FSM state encoding, parameter defaults, derived width helpers and
//          saturating add/sub functions shared by the trainer and its weight store.
// Ports:   none (package).

package perceptron_trainer_pkg;

  localparam int N_IN_DEF      = 8;
  localparam int W_W_DEF       = 8;
  localparam int THRESHOLD_DEF = 8;
  localparam int LR_DEF        = 1;

  // Width helpers: index into the weight vector, and an accumulator wide
  // enough that summing N_IN full-scale weights can never wrap.
  function automatic int idx_width(input int n_in);
    return $clog2(n_in);
  endfunction

  function automatic int acc_width(input int n_in, input int w_w);
    return w_w + $clog2(n_in) + 1;
  endfunction

  localparam int IDX_W_DEF = idx_width(N_IN_DEF);
  localparam int ACC_W_DEF = acc_width(N_IN_DEF, W_W_DEF);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCUM  = 3'd1,
    ST_DECIDE = 3'd2,
    ST_UPDATE = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  // Saturating increment: result clamps at max_v instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] v,
                                          input logic [31:0] step,
                                          input logic [31:0] max_v);
    logic [32:0] s;
    s = {1'b0, v} + {1'b0, step};
    if (s > {1'b0, max_v}) return max_v;
    return s[31:0];
  endfunction

  // Saturating decrement: result clamps at zero instead of wrapping.
  function automatic logic [31:0] sat_sub(input logic [31:0] v,
                                          input logic [31:0] step);
    if (v < step) return 32'd0;
    return v - step;
  endfunction

endpackage

// File: rtl/perceptron_trainer_weight_store.sv
// rtl/perceptron_trainer_weight_store.sv - weight and bias register file with one write port and async reads
//
// Purpose: holds N_IN weights plus the bias. One synchronous write port shared
//          by configuration preload and training updates; two combinational
//          weight read ports (external inference fetch, internal datapath).
// Ports:
//   clk, rst             clock, synchronous active-high reset (clears all entries)
//   we, wr_idx, wr_data  write strobe, index (N_IN selects bias), value
//   rd_idx, rd_weight    external read port, combinational
//   acc_idx, acc_weight  internal read port used by accumulate/update
//   bias                 current bias value

module perceptron_weight_store #(
  parameter int N_IN  = 8,
  parameter int W_W   = 8,
  parameter int IDX_W = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W:0]   wr_idx,
  input  logic [W_W-1:0]   wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [W_W-1:0]   rd_weight,
  input  logic [IDX_W-1:0] acc_idx,
  output logic [W_W-1:0]   acc_weight,
  output logic [W_W-1:0]   bias
);

  logic [W_W-1:0] weights [N_IN];
  logic [W_W-1:0] bias_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_IN; k++) begin
        weights[k] <= '0;
      end
      bias_q <= '0;
    end else if (we) begin
      // Index N_IN addresses the bias; anything above it is silently dropped.
      if (wr_idx == (IDX_W+1)'(N_IN)) begin
        bias_q <= wr_data;
      end else if (wr_idx < (IDX_W+1)'(N_IN)) begin
        weights[wr_idx[IDX_W-1:0]] <= wr_data;
      end
    end
  end

  assign rd_weight  = weights[rd_idx];
  assign acc_weight = weights[acc_idx];
  assign bias       = bias_q;

endmodule

// File: rtl/perceptron_trainer.sv
// rtl/perceptron_trainer.sv - serial perceptron training engine owning the weight/bias store
//
// Purpose: accepts labelled binary samples, accumulates the weighted sum one
//          input per cycle, predicts against THRESHOLD, and on a misprediction
//          applies the perceptron rule (weights of active inputs and the bias
//          step by LR toward the label, saturating). Exposes the store for reads.
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   sample_valid/ready, sample_x/label    sample handshake and payload
//   result_valid/ready, result_pred/err   result handshake, prediction and error flag
//   cfg_we, cfg_idx, cfg_data             preload write (honoured only in IDLE)
//   rd_idx, rd_weight, bias_out           combinational weight/bias read
//   err_count, clr_stats                  saturating misprediction counter and clear

module perceptron_trainer
  import perceptron_trainer_pkg::*;
#(
  parameter int N_IN      = N_IN_DEF,
  parameter int W_W       = W_W_DEF,
  parameter int THRESHOLD = THRESHOLD_DEF,
  parameter int LR        = LR_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  input  logic [N_IN-1:0]         sample_x,
  input  logic                    sample_label,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    result_pred,
  output logic                    result_err,
  input  logic                    cfg_we,
  input  logic [$clog2(N_IN):0]   cfg_idx,
  input  logic [W_W-1:0]          cfg_data,
  input  logic [$clog2(N_IN)-1:0] rd_idx,
  output logic [W_W-1:0]          rd_weight,
  output logic [W_W-1:0]          bias_out,
  output logic [15:0]             err_count,
  input  logic                    clr_stats
);

  localparam int IDX_W = idx_width(N_IN);
  localparam int ACC_W = acc_width(N_IN, W_W);
  localparam int CNT_W = IDX_W + 1;
  localparam int SUM_W = ACC_W + 1;
  localparam logic [31:0] W_MAX = 32'({W_W{1'b1}});

  state_t            state_q, state_d;
  logic [N_IN-1:0]   x_q;
  logic              label_q;
  logic [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]  idx_q;
  logic              pred_q;
  logic              err_q;
  logic [15:0]       err_count_q;

  logic [IDX_W-1:0]  cur;
  logic [W_W-1:0]    cur_weight;
  logic [W_W-1:0]    bias_q;
  logic [SUM_W-1:0]  sum;
  logic              pred_now;
  logic              accum_last;
  logic              upd_last;
  logic [W_W-1:0]    upd_src;
  logic [W_W-1:0]    upd_val;

  logic              wr_en;
  logic [CNT_W-1:0]  wr_idx;
  logic [W_W-1:0]    wr_data;

  perceptron_weight_store #(
    .N_IN  (N_IN),
    .W_W   (W_W),
    .IDX_W (IDX_W)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .we         (wr_en),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .rd_idx     (rd_idx),
    .rd_weight  (rd_weight),
    .acc_idx    (cur),
    .acc_weight (cur_weight),
    .bias       (bias_q)
  );

  assign cur        = idx_q[IDX_W-1:0];
  assign sum        = SUM_W'(acc_q) + SUM_W'(bias_q);
  assign pred_now   = (sum >= SUM_W'(THRESHOLD));
  assign accum_last = (idx_q == CNT_W'(N_IN - 1));
  // The update walk runs one step past the last weight to reach the bias.
  assign upd_last   = (idx_q == CNT_W'(N_IN));
  assign upd_src    = upd_last ? bias_q : cur_weight;
  assign upd_val    = label_q ? W_W'(sat_add(32'(upd_src), 32'(LR), W_MAX))
                              : W_W'(sat_sub(32'(upd_src), 32'(LR)));

  always_comb begin
    state_d      = state_q;
    sample_ready = 1'b0;
    result_valid = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = cfg_idx;
    wr_data      = cfg_data;
    case (state_q)
      ST_IDLE: begin
        sample_ready = 1'b1;
        // A cfg write in the accept cycle lands before ACCUM's first read.
        wr_en = cfg_we;
        if (sample_valid) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (accum_last) state_d = ST_DECIDE;
      end
      ST_DECIDE: begin
        state_d = (pred_now != label_q) ? ST_UPDATE : ST_RESP;
      end
      ST_UPDATE: begin
        wr_en   = upd_last | x_q[cur];
        wr_idx  = idx_q;
        wr_data = upd_val;
        if (upd_last) state_d = ST_RESP;
      end
      ST_RESP: begin
        result_valid = 1'b1;
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      label_q     <= 1'b0;
      acc_q       <= '0;
      idx_q       <= '0;
      pred_q      <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (sample_valid) begin
            x_q     <= sample_x;
            label_q <= sample_label;
            acc_q   <= '0;
            idx_q   <= '0;
          end
        end
        ST_ACCUM: begin
          if (x_q[cur]) acc_q <= acc_q + ACC_W'(cur_weight);
          idx_q <= idx_q + 1'b1;
        end
        ST_DECIDE: begin
          pred_q <= pred_now;
          err_q  <= (pred_now != label_q);
          idx_q  <= '0;
        end
        ST_UPDATE: begin
          idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase

      // RESP is entered with err=1 only from the final UPDATE step.
      if (clr_stats) begin
        err_count_q <= '0;
      end else if (state_q == ST_UPDATE && upd_last && err_count_q != 16'hFFFF) begin
        err_count_q <= err_count_q + 16'd1;
      end
    end
  end

  assign result_pred = pred_q;
  assign result_err  = err_q;
  assign bias_out    = bias_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// tb/tb_perceptron_trainer.sv - scoreboard testbench for perceptron_trainer

module tb_perceptron_trainer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic        sample_ready;
  logic [7:0]  sample_x;
  logic        sample_label;
  logic        result_valid;
  logic        result_ready;
  logic        result_pred;
  logic        result_err;
  logic        cfg_we;
  logic [3:0]  cfg_idx;
  logic [7:0]  cfg_data;
  logic [2:0]  rd_idx;
  logic [7:0]  rd_weight;
  logic [7:0]  bias_out;
  logic [15:0] err_count;
  logic        clr_stats;

  perceptron_trainer dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_x     (sample_x),
    .sample_label (sample_label),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_pred  (result_pred),
    .result_err   (result_err),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_data     (cfg_data),
    .rd_idx       (rd_idx),
    .rd_weight    (rd_weight),
    .bias_out     (bias_out),
    .err_count    (err_count),
    .clr_stats    (clr_stats)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic pred;
    logic err;
    int   lat;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, measures latency from the accept
  // cycle to the first result_valid cycle, checks every presented result.
  int   ncyc    = 0;
  int   acc_cyc = 0;
  logic prev_v  = 1'b0;

  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (sample_valid && sample_ready) acc_cyc = ncyc;
      if (result_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          if (!prev_v) check("latency", ncyc - acc_cyc, sb[0].lat);
          check("result_pred", int'(result_pred), int'(sb[0].pred));
          check("result_err", int'(result_err), int'(sb[0].err));
          if (result_ready) void'(sb.pop_front());
        end
      end
      prev_v = result_valid && !result_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int idx, input int data);
    cfg_we   = 1'b1;
    cfg_idx  = 4'(idx);
    cfg_data = 8'(data);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input int x, input int lbl, input int p, input int e, input int lat);
    int n;
    exp_t item;
    item.pred = 1'(p);
    item.err  = 1'(e);
    item.lat  = lat;
    sb.push_back(item);
    sample_x     = 8'(x);
    sample_label = 1'(lbl);
    sample_valid = 1'b1;
    n = 0;
    while (!sample_ready && n < 50) begin
      tick();
      n++;
    end
    if (!sample_ready) check("accept_timeout", 0, 1);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("resp_timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_w(input int idx, input int exp);
    rd_idx = 3'(idx);
    #1;
    check($sformatf("w%0d", idx), int'(rd_weight), exp);
  endtask

  task automatic check_all_zero();
    for (int k = 0; k < 8; k++) check_w(k, 0);
    check("bias", int'(bias_out), 0);
    check("err_count", int'(err_count), 0);
    check("sample_ready", int'(sample_ready), 1);
    check("result_valid", int'(result_valid), 0);
    check("result_pred", int'(result_pred), 0);
    check("result_err", int'(result_err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; sample_valid = 1'b0; sample_x = '0; sample_label = 1'b0;
    result_ready = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;
    rd_idx = '0; clr_stats = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check_all_zero();
    tick();

    // Zero weights: sum 0 < 8, label 1 -> error, w0 and bias step to 1.
    send(8'h01, 1, 0, 1, 19);
    wait_done();
    check_w(0, 1);
    for (int k = 1; k < 8; k++) check_w(k, 0);
    check("bias", int'(bias_out), 1);
    check("err_count", int'(err_count), 1);
    tick();

    // w0..3=4, bias 0: x=03 sums to 8 >= 8 -> correct, nothing changes.
    for (int k = 0; k < 4; k++) cfg_write(k, 4);
    cfg_write(8, 0);
    send(8'h03, 1, 1, 0, 10);
    wait_done();
    for (int k = 0; k < 4; k++) check_w(k, 4);
    check("bias", int'(bias_out), 0);
    check("err_count", int'(err_count), 1);
    tick();

    // Full-scale weight, label 1 -> correct.
    cfg_write(7, 255);
    send(8'h80, 1, 1, 0, 10);
    wait_done();
    check_w(7, 255);
    tick();

    // Zero weight, label 0 -> correct, no underflow.
    cfg_write(8, 0);
    cfg_write(7, 0);
    send(8'h80, 0, 0, 0, 10);
    wait_done();
    check_w(7, 0);
    check("bias", int'(bias_out), 0);
    tick();

    // w7=255, label 0 -> error: w7 255->254, bias saturates at 0.
    cfg_write(7, 255);
    send(8'h80, 0, 1, 1, 19);
    wait_done();
    check_w(7, 254);
    check("bias", int'(bias_out), 0);
    check("err_count", int'(err_count), 2);
    tick();

    // w0=4 alone < 8, label 1 -> error: w0 5, bias 1, inactive w7 stays 255.
    cfg_write(7, 255);
    send(8'h01, 1, 0, 1, 19);
    wait_done();
    check_w(0, 5);
    check_w(3, 4);
    check_w(7, 255);
    check("bias", int'(bias_out), 1);
    check("err_count", int'(err_count), 3);
    tick();

    // Back-pressure: 5+1+4 = 10 >= 8 -> correct; result held, inputs ignored.
    result_ready = 1'b0;
    send(8'h03, 1, 1, 0, 10);
    n = 0;
    while (!result_valid && n < 30) begin
      tick();
      n++;
    end
    check("hold_valid_seen", int'(result_valid), 1);
    repeat (5) begin
      sample_valid = 1'b1; sample_x = 8'hFF; sample_label = 1'b0;
      cfg_we = 1'b1; cfg_idx = 4'd5; cfg_data = 8'd77;
      check("hold_sample_ready", int'(sample_ready), 0);
      check("hold_result_valid", int'(result_valid), 1);
      tick();
    end
    sample_valid = 1'b0;
    cfg_we = 1'b0;
    result_ready = 1'b1;
    wait_done();
    check_w(5, 0);
    check("hold_sample_ready_after", int'(sample_ready), 1);
    tick();

    // cfg write and sample accept in the same cycle: w0=7, bias 1 -> 8 >= 8.
    cfg_we = 1'b1; cfg_idx = 4'd0; cfg_data = 8'd7;
    send(8'h01, 1, 1, 0, 10);
    cfg_we = 1'b0;
    wait_done();
    check_w(0, 7);
    check("bias", int'(bias_out), 1);
    tick();

    // Reset in the middle of UPDATE: w0 already stepped to 6, w1 not yet.
    sample_x = 8'hFF; sample_label = 1'b0; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (10) tick();
    check_w(0, 6);
    check_w(1, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero();
    tick();

    // Clear held across the increment -> clear wins.
    clr_stats = 1'b1;
    send(8'h01, 1, 0, 1, 19);
    wait_done();
    clr_stats = 1'b0;
    check("err_count_cleared", int'(err_count), 0);
    check_w(0, 1);
    check("bias", int'(bias_out), 1);
    tick();

    // Counting resumes: 1+1 = 2 < 8 -> error again.
    send(8'h01, 1, 0, 1, 19);
    wait_done();
    check("err_count", int'(err_count), 1);
    check_w(0, 2);
    check("bias", int'(bias_out), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
